spi_slave_port: RTL and testbench
=================================

Name: spi_slave_port

Overview:
- SPI responder (peripheral) end of the CPU's SPI link. It receives `spi_clk`, `mosi` and `cs_n` from the SPI master and drives `miso`.
- Oversamples the SPI pins in the system clock domain. Deserialises MOSI into words and serialises a one-entry TX holding buffer onto MISO.
- Used as the bench/peripheral counterpart for the CPU SPI register file, and as the slave-side interface for on-chip devices.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.

Parameters:
W, 32, word width in bits (matches `W_CPU`).

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  asynchronous, active-high reset
spi_clk  input  1  SPI serial clock from master, asynchronous to clk
cs_n  input  1  chip select, active low, asynchronous
mosi  input  1  serial data from master
miso  output  1  serial data to master
tx_data  input  W  next word to transmit
tx_load  input  1  write strobe for tx_data
tx_ready  output  1  TX holding buffer empty
tx_underrun  output  1  one-cycle pulse: a word boundary found the buffer empty
rx_data  output  W  last complete received word
rx_valid  output  1  one-cycle pulse: rx_data was just updated
busy  output  1  frame in progress (state SHIFT)

Behaviour:
- Reset is asynchronous, active-high, on clk. Reset values:
  - miso=0, tx_ready=1, tx_underrun=0, rx_data=0, rx_valid=0, busy=0.
  - Shift registers and bit_cnt are 0. State is IDLE.
  - Synchroniser stages: spi_clk=0, cs_n=1, mosi=0.
- Synchronisers:
  - spi_clk, cs_n and mosi each pass through 2 flops, plus a third stage for edge detection.
  - sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3; cs_fall / cs_rise are detected the same way.
  - mosi uses the same depth, so it stays aligned with the edge detection.
- Timing requirement on the master: spi_clk high and low phases are each ≥3 clk periods. Shorter phases give undefined results.
- TX holding buffer:
  - tx_load with tx_ready=1 captures tx_data, and tx_ready falls on the next cycle.
  - tx_load with tx_ready=0 is ignored; the buffer is unchanged.
  - When a consume and a tx_load occur in the same cycle, the load is ignored, because tx_ready is still 0 that cycle.
- State machine:
  - IDLE: miso=0, bit_cnt=0. On cs_fall, perform a *load point*, then go to SHIFT.
  - SHIFT:
    - On sclk_rise: `rx_shift <= {rx_shift[W-2:0], mosi_s}`.
      - If bit_cnt==W-1: rx_data <= assembled word, rx_valid=1 for one cycle, bit_cnt <= 0, and set the reload flag.
      - Otherwise bit_cnt++.
    - On sclk_fall: if the reload flag is set, perform a load point and clear the flag. Otherwise shift tx_shift left, with miso = new MSB.
    - On cs_rise: go to IDLE. Partial RX bits are discarded with no rx_valid. tx_shift is discarded. bit_cnt=0, miso=0, reload flag cleared. The buffer is not refilled, so the consumed word is lost.
  - cs_rise takes priority over any sclk edge detected in the same cycle.
- Load point:
  - Buffer full: tx_shift <= buffer, buffer emptied (tx_ready=1 next cycle), miso = buffer MSB.
  - Buffer empty: tx_shift <= 0, tx_underrun pulses for one cycle.
- Latency: rx_valid is high in the clk cycle after the 3rd clk edge that follows the final spi_clk rising edge at the pin (±1 cycle, depending on sampling phase).
- rx_data holds its value until the next complete word. There is no RX backpressure; a host that misses the rx_valid pulse loses the word.
- Back-to-back words without deasserting cs_n are supported. The bit count wraps at W and each word raises its own rx_valid.
- Reset mid-frame: all state returns immediately to reset values. The next frame needs a new cs_fall.

Test Plan:
- Reset, then tx_load 0xA5A50001. Frame with cs_n low; master sends 0x12345678 at spi_clk=clk/8.
  -> Master captures 0xA5A50001 on miso; rx_data=0x12345678 with exactly one rx_valid pulse; tx_ready=1 within 2 cycles of cs_fall; tx_underrun never pulses.
- Two back-to-back words, cs_n held low. Load 0xCAFEF00D during word 1; master sends 0xDEADBEEF then 0x00000001.
  -> Two rx_valid pulses with those values; master receives the preloaded word, then 0xCAFEF00D.
- No tx_load before the frame; master sends 0xFFFFFFFF.
  -> miso stays 0 for all 32 bits; tx_underrun pulses once; rx_data=0xFFFFFFFF.
- cs_n raised after 13 bits, then a full frame of 0x0F0F0F0F.
  -> No rx_valid for the aborted frame; next rx_data=0x0F0F0F0F with busy correctly framed.
- tx_load 0x11111111, then tx_load 0x22222222 while tx_ready=0.
  -> Second load ignored; master receives 0x11111111.
- rst asserted at bit 20 of a frame.
  -> All outputs return to reset values asynchronously; the next full frame of 0x80000001 is received correctly.

Source files
------------

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder, MSB first. The SPI pins are oversampled in the clk
// domain. MOSI is deserialised into W-bit words. A one-entry TX holding
// buffer is serialised onto MISO, and each word boundary reloads the shifter
// from that buffer.
module spi_slave_port #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         spi_clk,
   input  logic         cs_n,
   input  logic         mosi,
   output logic         miso,
   input  logic [W-1:0] tx_data,
   input  logic         tx_load,
   output logic         tx_ready,
   output logic         tx_underrun,
   output logic [W-1:0] rx_data,
   output logic         rx_valid,
   output logic         busy
);

   localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state, state_nxt;
   logic               sclk_p0, sclk_p1, sclk_p2;
   logic               cs_p0, cs_p1, cs_p2;
   logic               mosi_p0, mosi_p1;
   logic               sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [W-2:0]       rx_shift;
   logic [W-1:0]       tx_shift;
   logic [W-1:0]       tx_buf;
   logic               buf_full;
   logic               reload;
   logic [CNT_W-1:0]   bit_cnt;
   logic               load_pt, rx_step, tx_step, abort;

   // Two-flop synchronisers plus a third stage for edge detection; mosi stops at p1 to line up with the edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         sclk_p2 <= 1'b0;
         cs_p0   <= 1'b1;
         cs_p1   <= 1'b1;
         cs_p2   <= 1'b1;
         mosi_p0 <= 1'b0;
         mosi_p1 <= 1'b0;
      end else begin
         sclk_p0 <= spi_clk;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         cs_p0   <= cs_n;
         cs_p1   <= cs_p0;
         cs_p2   <= cs_p1;
         mosi_p0 <= mosi;
         mosi_p1 <= mosi_p0;
      end
   end

   assign sclk_rise = sclk_p1 & ~sclk_p2;
   assign sclk_fall = ~sclk_p1 & sclk_p2;
   assign cs_fall   = ~cs_p1 & cs_p2;
   assign cs_rise   = cs_p1 & ~cs_p2;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: a frame runs from cs_n falling to cs_n rising
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cs_fall) state_nxt = SHIFT;
         SHIFT:   if (cs_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: decode which datapath action this cycle performs; cs_rise masks any sclk edge
   always_comb begin
      busy    = (state == SHIFT);
      load_pt = 1'b0;
      rx_step = 1'b0;
      tx_step = 1'b0;
      abort   = 1'b0;
      case (state)
         IDLE: load_pt = cs_fall;
         SHIFT: begin
            if (cs_rise) begin
               abort = 1'b1;
            end else begin
               rx_step = sclk_rise;
               if (sclk_fall) begin
                  if (reload) load_pt = 1'b1;
                  else        tx_step = 1'b1;
               end
            end
         end
         default: abort = 1'b1;
      endcase
   end

   // Shift datapath: sample MOSI on rising edges, advance MISO on falling edges, reload at word boundaries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_shift    <= '0;
         tx_shift    <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         bit_cnt     <= '0;
         reload      <= 1'b0;
         miso        <= 1'b0;
      end else begin
         rx_valid    <= 1'b0;
         tx_underrun <= 1'b0;
         if (abort) begin
            rx_shift <= '0;
            tx_shift <= '0;
            bit_cnt  <= '0;
            reload   <= 1'b0;
            miso     <= 1'b0;
         end else begin
            if (rx_step) begin
               rx_shift <= {rx_shift[W-3:0], mosi_p1};
               if (bit_cnt == LAST_BIT) begin
                  rx_data  <= {rx_shift, mosi_p1};
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
                  reload   <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            if (load_pt) begin
               reload <= 1'b0;
               if (buf_full) begin
                  tx_shift <= tx_buf;
                  miso     <= tx_buf[W-1];
               end else begin
                  tx_shift    <= '0;
                  miso        <= 1'b0;
                  tx_underrun <= 1'b1;
               end
            end else if (tx_step) begin
               tx_shift <= tx_shift << 1;
               miso     <= tx_shift[W-2];
            end
         end
      end
   end

   // Holding-buffer flag: a consume wins, and a load is accepted only while the buffer is empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_full <= 1'b0;
      end else if (load_pt && buf_full) begin
         buf_full <= 1'b0;
      end else if (tx_load && !buf_full) begin
         buf_full <= 1'b1;
      end
   end

   // Holding-buffer data: captured only when a load is accepted
   always_ff @(posedge clk) begin
      if (tx_load && !buf_full) tx_buf <= tx_data;
   end

   assign tx_ready = ~buf_full;

endmodule

// File: tb/tb_spi_slave_port.sv
`timescale 1ns/1ps
// Directed bench for spi_slave_port. A behavioural mode-0 SPI master runs at
// spi_clk = clk/8. It raises cs_n while spi_clk is still high after the last
// bit of a frame.
module tb_spi_slave_port;

   localparam int W    = 32;
   localparam int HALF = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         spi_clk = 1'b0;
   logic         cs_n = 1'b1;
   logic         mosi = 1'b0;
   logic         tx_load = 1'b0;
   logic [W-1:0] tx_data = '0;
   logic         miso, tx_ready, tx_underrun, rx_valid, busy;
   logic [W-1:0] rx_data;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           rxv_cnt, und_cnt;
   logic [W-1:0] rx_last, rx_prev;

   spi_slave_port #(.W(W)) dut (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulse monitor: counts rx_valid / tx_underrun pulses and keeps the last two received words
   always @(negedge clk) begin
      if (rst) begin
         rxv_cnt <= 0;
         und_cnt <= 0;
         rx_last <= '0;
         rx_prev <= '0;
      end else begin
         if (rx_valid) begin
            rxv_cnt <= rxv_cnt + 1;
            rx_prev <= rx_last;
            rx_last <= rx_data;
         end
         if (tx_underrun) und_cnt <= und_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_word(input logic [W-1:0] d);
      tx_data = d;
      tx_load = 1'b1;
      tick(1);
      tx_load = 1'b0;
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      tick(HALF);
   endtask

   task automatic cs_high();
      cs_n = 1'b1;
      tick(HALF);
      spi_clk = 1'b0;
      tick(2 * HALF);
   endtask

   // Sends mo[n-1:0] MSB first and returns what the master sampled on MISO in mi[n-1:0]; leaves spi_clk high
   task automatic bits(input int n, input logic [W-1:0] mo, output logic [W-1:0] mi);
      mi = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_clk = 1'b0;
         mosi    = mo[i];
         tick(HALF);
         mi      = {mi[W-2:0], miso};
         spi_clk = 1'b1;
         tick(HALF);
      end
   endtask

   initial begin
      logic [W-1:0] m1, m2;
      int rv0, un0;

      // Reset state
      tick(3);
      check("rst_miso", {31'd0, miso}, 32'd0);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
      check("rst_rx_data", rx_data, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick(2);

      // Single frame with a preloaded word
      load_word(32'hA5A50001);
      check("t1_ready_low", {31'd0, tx_ready}, 32'd0);
      rv0 = rxv_cnt; un0 = und_cnt;
      cs_low();
      check("t1_ready_after_csfall", {31'd0, tx_ready}, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      bits(32, 32'h12345678, m1);
      cs_high();
      check("t1_miso_word", m1, 32'hA5A50001);
      check("t1_rx_data", rx_last, 32'h12345678);
      check("t1_rx_pulses", 32'(rxv_cnt - rv0), 32'd1);
      check("t1_underruns", 32'(und_cnt - un0), 32'd0);
      check("t1_busy_end", {31'd0, busy}, 32'd0);

      // Back-to-back words, second TX word loaded mid-way through the first
      load_word(32'h0BADC0DE);
      rv0 = rxv_cnt; un0 = und_cnt;
      cs_low();
      bits(16, 32'hDEADBEEF >> 16, m1);
      load_word(32'hCAFEF00D);
      bits(16, 32'hDEADBEEF, m2);
      m1 = {m1[15:0], m2[15:0]};
      bits(32, 32'h00000001, m2);
      cs_high();
      check("t2_miso_w1", m1, 32'h0BADC0DE);
      check("t2_miso_w2", m2, 32'hCAFEF00D);
      check("t2_rx_w1", rx_prev, 32'hDEADBEEF);
      check("t2_rx_w2", rx_last, 32'h00000001);
      check("t2_rx_pulses", 32'(rxv_cnt - rv0), 32'd2);
      check("t2_underruns", 32'(und_cnt - un0), 32'd0);

      // Underrun: nothing loaded before the frame
      rv0 = rxv_cnt; un0 = und_cnt;
      cs_low();
      bits(32, 32'hFFFFFFFF, m1);
      cs_high();
      check("t3_miso_zero", m1, 32'd0);
      check("t3_underruns", 32'(und_cnt - un0), 32'd1);
      check("t3_rx_data", rx_last, 32'hFFFFFFFF);
      check("t3_rx_pulses", 32'(rxv_cnt - rv0), 32'd1);

      // Aborted frame after 13 bits, then a full frame
      rv0 = rxv_cnt;
      cs_low();
      bits(13, 32'h00001555, m1);
      cs_high();
      check("t4_abort_pulses", 32'(rxv_cnt - rv0), 32'd0);
      check("t4_abort_busy", {31'd0, busy}, 32'd0);
      check("t4_abort_rx_hold", rx_data, 32'hFFFFFFFF);
      cs_low();
      check("t4_busy", {31'd0, busy}, 32'd1);
      bits(32, 32'h0F0F0F0F, m1);
      cs_high();
      check("t4_rx_data", rx_last, 32'h0F0F0F0F);
      check("t4_rx_pulses", 32'(rxv_cnt - rv0), 32'd1);
      check("t4_busy_end", {31'd0, busy}, 32'd0);

      // Second load while the buffer is full is ignored
      load_word(32'h11111111);
      load_word(32'h22222222);
      check("t5_ready_low", {31'd0, tx_ready}, 32'd0);
      cs_low();
      bits(32, 32'h00000000, m1);
      cs_high();
      check("t5_miso_word", m1, 32'h11111111);
      check("t5_ready_end", {31'd0, tx_ready}, 32'd1);

      // Asynchronous reset at bit 20, then a clean frame
      load_word(32'h5A5A5A5A);
      cs_low();
      load_word(32'h7E7E7E7E);
      bits(20, 32'h000FFFFF, m1);
      check("t6_busy_pre", {31'd0, busy}, 32'd1);
      check("t6_ready_pre", {31'd0, tx_ready}, 32'd0);
      rst = 1'b1;
      #1;
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
      check("t6_rst_miso", {31'd0, miso}, 32'd0);
      check("t6_rst_rx_data", rx_data, 32'd0);
      check("t6_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("t6_rst_underrun", {31'd0, tx_underrun}, 32'd0);
      spi_clk = 1'b0;
      cs_n    = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(2);
      rv0 = rxv_cnt;
      cs_low();
      bits(32, 32'h80000001, m1);
      cs_high();
      check("t6_rx_data", rx_last, 32'h80000001);
      check("t6_rx_pulses", 32'(rxv_cnt - rv0), 32'd1);
      check("t6_miso_after_rst", m1, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
